// File: rtl/display_defs.sv
// Shared constants for the two-digit BCD display path.
// Segment patterns are active-high {g,f,e,d,c,b,a}.
package display_defs;

  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  typedef enum logic {
    SLOT_UNITS = 1'b0,
    SLOT_TENS  = 1'b1
  } slot_e;

endpackage

// File: rtl/display_bcd_mux_bcd_to_7seg.sv
// BCD digit to active-high {g..a} segment pattern.
// Codes 10-15 are not BCD and render as a dash.
module bcd_to_7seg
  import display_defs::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_bcd_mux.sv
// Time-multiplexed two-digit 7-segment driver with frame snapshot.
// Optional: LEADING_ZERO_BLANK_EN darkens the tens slot when it is 0.
module display_bcd_mux
  import display_defs::*;
#(
  parameter int SCAN_DIV         = 1000,
  parameter bit SEG_ACTIVE_LOW   = 1'b1,
  parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] units_bcd,
  input  logic [3:0] tens_bcd,
  input  logic       blank,
  output logic [6:0] seg,
  output logic [1:0] digit_en,
  output logic       frame_tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [6:0] SEG_IDLE =
    SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic [1:0] DIG_IDLE =
    DIGIT_ACTIVE_LOW ? 2'b11 : 2'b00;

  logic [CW-1:0] cnt_q, cnt_d;
  slot_e         slot_q, slot_d;
  logic [7:0]    snap_q, snap_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    dig_q, dig_d;
  logic          ft_q, ft_d;

  logic       tick;
  logic       frame_start;
  logic       lz_dark;
  logic       dark;
  logic [3:0] digit_sel;
  logic [1:0] en_hi;
  logic [6:0] pat;

  bcd_to_7seg u_dec (
    .bcd_i (digit_sel),
    .seg_o (pat)
  );

  // The units slot opens on the same edge the snapshot is taken,
  // so it reads the live inputs; the tens slot reads the snapshot.
  always_comb begin
    tick        = (cnt_q == CNT_LAST);
    cnt_d       = tick ? '0 : cnt_q + 1'b1;
    slot_d      = slot_q;
    frame_start = tick && (slot_q == SLOT_TENS);
    snap_d      = frame_start ? {tens_bcd, units_bcd} : snap_q;
    if (tick) begin
      slot_d = (slot_q == SLOT_TENS) ? SLOT_UNITS : SLOT_TENS;
    end
    digit_sel = (slot_q == SLOT_TENS) ? units_bcd : snap_q[7:4];
`ifdef LEADING_ZERO_BLANK_EN
    lz_dark = (slot_q == SLOT_UNITS) && (snap_q[7:4] == 4'd0);
`else
    lz_dark = 1'b0;
`endif
    dark  = blank | lz_dark;
    en_hi = (slot_q == SLOT_TENS) ? 2'b01 : 2'b10;
    seg_d = seg_q;
    dig_d = dig_q;
    if (tick) begin
      if (dark) begin
        seg_d = SEG_IDLE;
        dig_d = DIG_IDLE;
      end else begin
        seg_d = SEG_ACTIVE_LOW ? ~pat : pat;
        dig_d = DIGIT_ACTIVE_LOW ? ~en_hi : en_hi;
      end
    end
    ft_d = frame_start;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      slot_q <= SLOT_TENS;
      snap_q <= '0;
      seg_q  <= SEG_IDLE;
      dig_q  <= DIG_IDLE;
      ft_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
      snap_q <= snap_d;
      seg_q  <= seg_d;
      dig_q  <= dig_d;
      ft_q   <= ft_d;
    end
  end

  assign seg        = seg_q;
  assign digit_en   = dig_q;
  assign frame_tick = ft_q;

endmodule
